stream_mux_rr: RTL and testbench

//  Parametrised NCH:1 stream multiplexer with a registered output and valid/ready handshakes.

---
 rtl/stream_mux_rr.sv | 117 +++++++++++
 tb/tb_stream_mux_rr.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/stream_mux_rr.sv
// NCH:1 stream multiplexer with a registered output; fixed-select or round-robin grant.
// Define STREAM_MUX_LOCK_EN to add in_last/out_last and hold the grant until a packet ends.
module stream_mux_rr #(
  parameter int WIDTH = 16,
  parameter int NCH   = 4,
  parameter int SELW  = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
`ifdef STREAM_MUX_LOCK_EN
  input  logic [NCH-1:0]       in_last,
  output logic                 out_last,
`endif
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_ch,
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam int unsigned NCHU = NCH;

  logic [SELW-1:0]  rr_ptr;
  logic [SELW-1:0]  gnt;
  logic             gnt_vld;
  logic [SELW-1:0]  rr_nxt;
  logic [WIDTH-1:0] gnt_data;
  logic             space;
  logic             xfer;
  int unsigned      idx;
  logic [SELW-1:0]  idx_s;

`ifdef STREAM_MUX_LOCK_EN
  logic             lock;
  logic [SELW-1:0]  lock_ch;
`endif

  assign space  = !out_valid || out_ready;
  assign xfer   = !rst && space && gnt_vld;
  assign rr_nxt = (gnt == SELW'(NCH - 1)) ? '0 : gnt + SELW'(1);

  always_comb begin
    gnt     = '0;
    gnt_vld = 1'b0;
    idx     = 0;
    idx_s   = '0;
`ifdef STREAM_MUX_LOCK_EN
    if (lock) begin
      gnt     = lock_ch;
      gnt_vld = in_valid[lock_ch];
    end else
`endif
    if (!mode) begin
      // Out-of-range select simply grants nothing.
      if (int'(sel) < NCH) begin
        gnt     = sel;
        gnt_vld = in_valid[sel];
      end
    end else begin
      for (int unsigned k = 0; k < NCHU; k++) begin
        idx = k + 32'(rr_ptr);
        if (idx >= NCHU) idx = idx - NCHU;
        idx_s = SELW'(idx);
        if (!gnt_vld && in_valid[idx_s]) begin
          gnt     = idx_s;
          gnt_vld = 1'b1;
        end
      end
    end
  end

  always_comb begin
    gnt_data = '0;
    for (int unsigned i = 0; i < NCHU; i++) begin
      if (SELW'(i) == gnt) gnt_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    in_ready = '0;
    if (xfer) in_ready[gnt] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      rr_ptr    <= '0;
`ifdef STREAM_MUX_LOCK_EN
      out_last  <= 1'b0;
      lock      <= 1'b0;
      lock_ch   <= '0;
`endif
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= gnt_data;
      out_ch    <= gnt;
`ifdef STREAM_MUX_LOCK_EN
      out_last  <= in_last[gnt];
      lock      <= !in_last[gnt];
      lock_ch   <= gnt;
      // Pointer moves only at packet boundaries so packets never interleave.
      if (mode && in_last[gnt]) rr_ptr <= rr_nxt;
`else
      if (mode) rr_ptr <= rr_nxt;
`endif
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed scoreboard bench for stream_mux_rr (WIDTH=16, NCH=4).
// Packet-lock steps run only when STREAM_MUX_LOCK_EN is defined.
module tb_stream_mux_rr;

  logic        clk = 1'b0;
  logic        rst;
  logic        mode;
  logic [1:0]  sel;
  logic [63:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [3:0]  lastv;
  logic [15:0] out_data;
  logic [1:0]  out_ch;
  logic        out_valid;
  logic        out_ready;
`ifdef STREAM_MUX_LOCK_EN
  logic        out_last;
`endif

  logic [15:0] chdata [4];

  typedef struct {
    logic [15:0] d;
    logic [1:0]  c;
    logic        l;
  } exp_t;
  exp_t q[$];

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  logic [15:0] last_d = '0;
  logic [1:0]  last_c = '0;

  localparam logic [3:0] LALL = 4'hF;

  stream_mux_rr #(.WIDTH(16), .NCH(4)) dut (
    .clk(clk),
    .rst(rst),
    .mode(mode),
    .sel(sel),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
`ifdef STREAM_MUX_LOCK_EN
    .in_last(lastv),
    .out_last(out_last),
`endif
    .out_data(out_data),
    .out_ch(out_ch),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock of stimulus; e is the expected granted channel (-1 = none).
  task automatic step(input logic r, input logic [3:0] v, input logic m, input logic [1:0] s,
                      input logic ordy, input logic [3:0] lst, input int e, input bit keep);
    exp_t x;
    logic [3:0] mask;
    @(negedge clk);
    if (!keep) for (int i = 0; i < 4; i++) chdata[i] = 16'($urandom);
    rst       = r;
    in_valid  = v;
    mode      = m;
    sel       = s;
    out_ready = ordy;
    lastv     = lst;
    in_data   = {chdata[3], chdata[2], chdata[1], chdata[0]};
    #1;
    mask = (e >= 0) ? (4'b0001 << e) : 4'b0000;
    chk("in_ready", 32'(in_ready), 32'(mask));
    if (e >= 0) begin
      x.d = chdata[e];
      x.c = 2'(e);
      x.l = lst[e];
      q.push_back(x);
    end
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      x = q.pop_front();
      chk("beat_valid", 32'(out_valid), 32'd1);
      chk("beat_data", 32'(out_data), 32'(x.d));
      chk("beat_ch", 32'(out_ch), 32'(x.c));
`ifdef STREAM_MUX_LOCK_EN
      chk("beat_last", 32'(out_last), 32'(x.l));
`endif
      last_d = x.d;
      last_c = x.c;
    end else if (r) begin
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_data", 32'(out_data), 32'd0);
      chk("rst_ch", 32'(out_ch), 32'd0);
    end else if (ordy) begin
      chk("idle_valid", 32'(out_valid), 32'd0);
    end else begin
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_data", 32'(out_data), 32'(last_d));
      chk("hold_ch", 32'(out_ch), 32'(last_c));
    end
  endtask

  initial begin
    rst = 1'b1; mode = 1'b0; sel = '0; in_valid = '0; out_ready = 1'b1;
    lastv = LALL; in_data = '0;
    for (int i = 0; i < 4; i++) chdata[i] = '0;

    // Reset
    step(1'b1, 4'hF, 1'b0, 2'd0, 1'b1, LALL, -1, 1'b0);
    step(1'b1, 4'hF, 1'b0, 2'd0, 1'b1, LALL, -1, 1'b0);
    step(1'b0, 4'h0, 1'b0, 2'd0, 1'b1, LALL, -1, 1'b0);

    // Fixed select
    for (int i = 0; i < 4; i++) chdata[i] = 16'($urandom);
    chdata[2] = 16'hBEEF;
    step(1'b0, 4'hF, 1'b0, 2'd2, 1'b1, LALL, 2, 1'b1);
    chk("sel2_beef", 32'(out_data), 32'h0000BEEF);
    step(1'b0, 4'b1011, 1'b0, 2'd2, 1'b1, LALL, -1, 1'b0);

    // Round-robin, all valid
    for (int i = 0; i < 8; i++) step(1'b0, 4'hF, 1'b1, 2'd0, 1'b1, LALL, i % 4, 1'b0);

    // Round-robin, ch1 and ch3 only
    for (int i = 0; i < 4; i++) step(1'b0, 4'b1010, 1'b1, 2'd0, 1'b1, LALL, (i % 2 != 0) ? 3 : 1, 1'b0);

    // Backpressure hold
    for (int i = 0; i < 4; i++) chdata[i] = 16'($urandom);
    chdata[0] = 16'h1234;
    step(1'b0, 4'b0001, 1'b1, 2'd0, 1'b1, LALL, 0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 4'hF, 1'b1, 2'd0, 1'b0, LALL, -1, 1'b0);
    step(1'b0, 4'hF, 1'b1, 2'd0, 1'b1, LALL, 1, 1'b0);

    // Mode 0 leaves rr_ptr alone; wrap from ch3 back to ch0
    step(1'b0, 4'hF, 1'b0, 2'd3, 1'b1, LALL, 3, 1'b0);
    step(1'b0, 4'hF, 1'b1, 2'd0, 1'b1, LALL, 2, 1'b0);
    step(1'b0, 4'b0001, 1'b1, 2'd0, 1'b1, LALL, 0, 1'b0);
    step(1'b0, 4'h0, 1'b1, 2'd0, 1'b1, LALL, -1, 1'b0);

`ifdef STREAM_MUX_LOCK_EN
    step(1'b1, 4'h0, 1'b1, 2'd0, 1'b1, LALL, -1, 1'b0);
    step(1'b0, 4'b0011, 1'b1, 2'd0, 1'b1, 4'b0000, 0, 1'b0);
    step(1'b0, 4'b0011, 1'b1, 2'd0, 1'b1, 4'b0000, 0, 1'b0);
    step(1'b0, 4'b0011, 1'b1, 2'd0, 1'b1, 4'b0001, 0, 1'b0);
    step(1'b0, 4'b0011, 1'b1, 2'd0, 1'b1, LALL, 1, 1'b0);
    // Reset in mid-packet from ch0
    step(1'b1, 4'h0, 1'b1, 2'd0, 1'b1, LALL, -1, 1'b0);
    step(1'b0, 4'b0011, 1'b1, 2'd0, 1'b1, 4'b0000, 0, 1'b0);
    step(1'b1, 4'b0011, 1'b1, 2'd0, 1'b1, 4'b0000, -1, 1'b0);
    step(1'b0, 4'b0011, 1'b1, 2'd0, 1'b1, LALL, 0, 1'b0);
    // Reset in mid-packet from ch1: lock must not survive
    step(1'b1, 4'h0, 1'b1, 2'd0, 1'b1, LALL, -1, 1'b0);
    step(1'b0, 4'b0010, 1'b1, 2'd0, 1'b1, 4'b0000, 1, 1'b0);
    step(1'b1, 4'b0011, 1'b1, 2'd0, 1'b1, 4'b0000, -1, 1'b0);
    step(1'b0, 4'b0011, 1'b1, 2'd0, 1'b1, LALL, 0, 1'b0);
    step(1'b0, 4'h0, 1'b1, 2'd0, 1'b1, LALL, -1, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
